// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the shared-adder arbiter.
// Optional feature macro: ADDER_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package adder_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int idWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester-side bus of the shared-adder arbiter: requests/operands in, grant/result out.
// Optional feature macro: ADDER_ARB_FIXED_PRIO_EN (no effect on the bus itself).
interface adder_arbiter_if
  import adder_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
);
  localparam int IDW = idWidth(NREQ);

  logic [NREQ-1:0]   Req;
  logic [NREQ*W-1:0] A;
  logic [NREQ*W-1:0] B;
  logic [NREQ-1:0]   Cin;
  logic [NREQ-1:0]   Gnt;
  logic              Busy;
  logic              Valid;
  logic [IDW-1:0]    ValidId;
  logic [W-1:0]      Sum;
  logic              Overflow;

  modport master (
    output Req, A, B, Cin,
    input  Gnt, Busy, Valid, ValidId, Sum, Overflow
  );

  modport slave (
    input  Req, A, B, Cin,
    output Gnt, Busy, Valid, ValidId, Sum, Overflow
  );

endinterface

// File: rtl/adder_arbiter_pick.sv
// Combinational winner picker: round-robin from ptr by default, lowest index wins
// when ADDER_ARB_FIXED_PRIO_EN is defined.
module adder_arb_pick
  import adder_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = idWidth(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  winner,
  output logic            found
);

`ifdef ADDER_ARB_FIXED_PRIO_EN
  logic unusedPtr;
  assign unusedPtr = ^ptr;

  // Scanning downward lets the lowest set index overwrite everything above it.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        winner = IDW'(j);
        found  = 1'b1;
      end
    end
  end
`else
  // Offsets are scanned from farthest to nearest so the first set bit at or after ptr wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (req[j] && (j == ((int'(ptr) + i) % NREQ))) begin
          winner = IDW'(j);
          found  = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/adder_arbiter.sv
// Shares one registered W-bit adder among NREQ requesters; grant, capture, add, tag result.
// Optional feature macro: ADDER_ARB_FIXED_PRIO_EN (fixed priority, no round-robin pointer).
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic           Clk,
  input  logic           Rst,
  adder_arbiter_if.slave bus
);
  localparam int IDW = idWidth(NREQ);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  winner;
  logic            found;
  logic [IDW-1:0]  id;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            c;
  logic [W-1:0]    selA;
  logic [W-1:0]    selB;
  logic            selC;

  logic [NREQ-1:0] gntQ;
  logic            busyQ;
  logic            validQ;
  logic [IDW-1:0]  validIdQ;
  logic [W-1:0]    sumQ;
  logic            ovfQ;

  adder_arb_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (bus.Req),
    .ptr    (ptr),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    selA = '0;
    selB = '0;
    selC = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (winner == IDW'(j)) begin
        selA = bus.A[j*W +: W];
        selB = bus.B[j*W +: W];
        selC = bus.Cin[j];
      end
    end
  end

  // Grant and operand capture happen on the same edge, so later operand changes are invisible.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      gntQ     <= '0;
      busyQ    <= 1'b0;
      validQ   <= 1'b0;
      validIdQ <= '0;
      sumQ     <= '0;
      ovfQ     <= 1'b0;
      a        <= '0;
      b        <= '0;
      c        <= 1'b0;
      id       <= '0;
    end else begin
      gntQ   <= '0;
      validQ <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gntQ  <= NREQ'(1) << winner;
            a     <= selA;
            b     <= selB;
            c     <= selC;
            id    <= winner;
            busyQ <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          {ovfQ, sumQ} <= {1'b0, a} + {1'b0, b} + (W + 1)'(c);
          validQ       <= 1'b1;
          validIdQ     <= id;
          busyQ        <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          busyQ <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ADDER_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  // The pointer moves just past each winner, wrapping from the top index to zero.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ptr <= '0;
    end else if (state == IDLE && found) begin
      ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end
`endif

  assign bus.Gnt      = gntQ;
  assign bus.Busy     = busyQ;
  assign bus.Valid    = validQ;
  assign bus.ValidId  = validIdQ;
  assign bus.Sum      = sumQ;
  assign bus.Overflow = ovfQ;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: vector table, directed corner sequences and a
// randomized run against a simple arbitration/arithmetic model.
module tb_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 4;

  typedef struct {
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] expSum;
    logic         expOvf;
  } vec_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   nChecks = 0;
  int   nFail   = 0;

  adder_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin);
    bus.A[idx*W +: W] = a;
    bus.B[idx*W +: W] = b;
    bus.Cin[idx]      = cin;
    bus.Req[idx]      = 1'b1;
  endtask

  task automatic checkGrantCycle(input string tag, input int expIdx);
    checkOutput({tag, " gnt"}, 32'(bus.Gnt), 32'(1) << expIdx);
    checkOutput({tag, " busy"}, 32'(bus.Busy), 32'd1);
    checkOutput({tag, " valid low"}, 32'(bus.Valid), 32'd0);
  endtask

  task automatic checkResultCycle(input string tag, input int expId, input int expSum,
                                  input int expOvf);
    checkOutput({tag, " valid"}, 32'(bus.Valid), 32'd1);
    checkOutput({tag, " validid"}, 32'(bus.ValidId), 32'(expId));
    checkOutput({tag, " sum"}, 32'(bus.Sum), 32'(expSum));
    checkOutput({tag, " ovf"}, 32'(bus.Overflow), 32'(expOvf));
    checkOutput({tag, " gnt low"}, 32'(bus.Gnt), 32'd0);
    checkOutput({tag, " busy low"}, 32'(bus.Busy), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " gnt"}, 32'(bus.Gnt), 32'd0);
    checkOutput({tag, " busy"}, 32'(bus.Busy), 32'd0);
    checkOutput({tag, " valid"}, 32'(bus.Valid), 32'd0);
    checkOutput({tag, " validid"}, 32'(bus.ValidId), 32'd0);
    checkOutput({tag, " sum"}, 32'(bus.Sum), 32'd0);
    checkOutput({tag, " ovf"}, 32'(bus.Overflow), 32'd0);
  endtask

  task automatic doReset();
    Rst     = 1'b1;
    bus.Req = '0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  // Winner by the arbitration rule alone: first set bit from the pointer, or lowest set bit.
  function automatic int modelWinner(input logic [NREQ-1:0] mask, input int p);
`ifdef ADDER_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (mask[i]) return i;
`else
    for (int k = 0; k < NREQ; k++) if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return -1;
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   modelPtr;
    int   expGrant;
    int   opA[NREQ];
    int   opB[NREQ];
    int   opC[NREQ];

    bus.Req = '0;
    bus.A   = '0;
    bus.B   = '0;
    bus.Cin = '0;

    vecs[0] = '{0, 4'h7, 4'h8, 1'b1, 4'h0, 1'b1};
    vecs[1] = '{1, 4'h3, 4'h2, 1'b0, 4'h5, 1'b0};
    vecs[2] = '{2, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    vecs[3] = '{3, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    vecs[4] = '{3, 4'h9, 4'h6, 1'b1, 4'h0, 1'b1};
    vecs[5] = '{2, 4'hA, 4'h5, 1'b0, 4'hF, 1'b0};

    repeat (2) @(posedge Clk);
    #1;
    checkAllZero("reset");
    Rst = 1'b0;
    tick();
    checkOutput("idle gnt", 32'(bus.Gnt), 32'd0);
    checkOutput("idle valid", 32'(bus.Valid), 32'd0);

    for (int v = 0; v < 6; v++) begin
      bus.Req = '0;
      applyStimulus(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].cin);
      tick();
      checkGrantCycle($sformatf("vec%0d", v), vecs[v].idx);
      bus.Req = '0;
      tick();
      checkResultCycle($sformatf("vec%0d", v), vecs[v].idx, int'(vecs[v].expSum),
                       int'(vecs[v].expOvf));
    end

    bus.Req = '0;
    applyStimulus(1, 4'd3, 4'd2, 1'b0);
    tick();
    checkGrantCycle("late operand", 1);
    bus.A[1*W +: W] = 4'd9;
    bus.Req = '0;
    tick();
    checkResultCycle("late operand", 1, 5, 0);

    doReset();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, W'(i), 4'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
      expGrant = 0;
`else
      expGrant = k % NREQ;
`endif
      tick();
      checkGrantCycle($sformatf("allreq%0d", k), expGrant);
      tick();
      checkResultCycle($sformatf("allreq%0d", k), expGrant, expGrant + 1, 0);
    end
    bus.Req = '0;
    tick();
    checkOutput("allreq drop gnt", 32'(bus.Gnt), 32'd0);

    doReset();
    applyStimulus(3, 4'd2, 4'd3, 1'b0);
    tick();
    checkGrantCycle("wrap a", 3);
    applyStimulus(0, 4'd1, 4'd1, 1'b0);
    tick();
    checkResultCycle("wrap a", 3, 5, 0);
    tick();
    checkGrantCycle("wrap b", 0);
    bus.Req[0] = 1'b0;
    tick();
    checkResultCycle("wrap b", 0, 2, 0);
    tick();
    checkGrantCycle("wrap c", 3);
    bus.Req = '0;
    tick();
    checkResultCycle("wrap c", 3, 5, 0);

    doReset();
    applyStimulus(0, 4'd5, 4'd5, 1'b0);
    tick();
    bus.Req = '0;
    tick();
    checkResultCycle("pre-reset", 0, 10, 0);
    applyStimulus(1, 4'd4, 4'd4, 1'b0);
    tick();
    checkGrantCycle("mid reset", 1);
    Rst = 1'b1;
    #1;
    checkAllZero("async reset");
    bus.Req = '0;
    #1;
    Rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("post reset gnt%0d", k), 32'(bus.Gnt), 32'd0);
      checkOutput($sformatf("post reset valid%0d", k), 32'(bus.Valid), 32'd0);
    end
    applyStimulus(1, 4'd1, 4'd2, 1'b0);
    applyStimulus(3, 4'd6, 4'd6, 1'b0);
    tick();
    checkGrantCycle("ptr restart", 1);
    bus.Req = '0;
    tick();
    checkResultCycle("ptr restart", 1, 3, 0);

    doReset();
    modelPtr = 0;
    for (int it = 0; it < 40; it++) begin
      logic [NREQ-1:0] mask;
      int              w;
      int              total;
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int j = 0; j < NREQ; j++) begin
        opA[j] = int'($urandom_range(0, (1 << W) - 1));
        opB[j] = int'($urandom_range(0, (1 << W) - 1));
        opC[j] = int'($urandom_range(0, 1));
        bus.A[j*W +: W] = W'(opA[j]);
        bus.B[j*W +: W] = W'(opB[j]);
        bus.Cin[j]      = opC[j][0];
      end
      bus.Req = mask;
      tick();
      w = modelWinner(mask, modelPtr);
      checkGrantCycle($sformatf("rand%0d", it), w);
      bus.A   = (NREQ*W)'($urandom);
      bus.B   = (NREQ*W)'($urandom);
      bus.Req = NREQ'($urandom);
      total   = opA[w] + opB[w] + opC[w];
      tick();
      checkResultCycle($sformatf("rand%0d", it), w, total % (1 << W), total / (1 << W));
      modelPtr = (w + 1) % NREQ;
      bus.Req  = '0;
      if ($urandom_range(0, 3) == 0) begin
        tick();
        checkOutput($sformatf("rand%0d idle gnt", it), 32'(bus.Gnt), 32'd0);
        checkOutput($sformatf("rand%0d idle valid", it), 32'(bus.Valid), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares a single W-bit registered adder among NREQ requesters. Each requester presents operands and a carry-in with a request. The block grants one requester at a time (round-robin by default), captures that requester's operands into the adder input registers, and returns Sum/Overflow tagged with the winner's index. It sits between the requesting units and the adder datapath, replacing per-unit adders in the counter subsystem.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 4, operand/sum width

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-high reset
- Req  input  NREQ  per-requester request, level; hold until own Gnt bit seen
- A  input  NREQ*W  packed operand A, requester i at [i*W +: W]
- B  input  NREQ*W  packed operand B, same packing
- Cin  input  NREQ  per-requester carry-in
- Gnt  output  NREQ  one-hot grant, one-cycle pulse
- Busy  output  1  high while an operation is in flight (state EXEC)
- Valid  output  1  one-cycle pulse: Sum/Overflow/ValidId are new
- ValidId  output  clog2(NREQ)  index of the requester owning the result
- Sum  output  W  result bits [W-1:0]
- Overflow  output  1  carry-out, bit W of A+B+Cin (unsigned)

## Operation
- Two-state FSM: IDLE, EXEC. Reset state is IDLE.
- IDLE, no Req bit set: hold. Gnt=0.
- IDLE, any Req bit set, on the clock edge:
  - pick winner
  - Gnt <= onehot(winner)
  - latch A/B/Cin slices of winner into internal a/b/c registers
  - latch winner into id register; pointer <= winner+1 mod NREQ
  - state <= EXEC
- EXEC, on the clock edge:
  - {Overflow,Sum} <= a+b+c, W+1-bit result, no truncation
  - Valid <= 1, ValidId <= id, Gnt <= 0
  - state <= IDLE
- Valid, Gnt: cleared to 0 on every edge where they are not set.
- Sum/Overflow/ValidId hold the last result until the next Valid.
- Round-robin pick: first set Req bit scanning from pointer upward, wrapping at NREQ-1 -> 0. Pointer resets to 0.
- Requesters: a requester must drop Req on the edge after seeing its Gnt. If it keeps Req asserted, that is a new request and competes normally.
- Operands are sampled only at the grant edge. Changes after that edge do not affect the result.
- Req bits that rise during EXEC are ignored until the next IDLE edge. They are not lost if still held.

## Timing
- Req sampled at edge k (state IDLE):
  - Gnt and Busy high in cycle k..k+1
  - Valid high in cycle k+1..k+2
- Latency: 2 edges from request sample to Valid.
- Throughput: one operation per 2 cycles; no back-to-back grants.
- Reset values: Gnt=0, Busy=0, Valid=0, ValidId=0, Sum=0, Overflow=0. Internal a, b, c, id, pointer = 0.
- Rst asserted mid-operation: everything clears immediately. The in-flight op is discarded, with no Valid and no later Gnt for it.
- Simultaneous Req from all requesters after reset: grants occur in order 0,1,2,3,0,...
- Wrap-around: winner NREQ-1 sets pointer to 0.

## Configuration
- ADDER_ARB_FIXED_PRIO_EN defined:
  - lowest set Req index always wins
  - pointer register is not implemented
  - ValidId/Gnt follow fixed priority
- ADDER_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Structure
- Package adder_arb_pkg holds:
  - state enum (IDLE, EXEC)
  - default NREQ and W constants
  - id-width constant/function clog2(NREQ)
- Sub-module adder_arb_pick: combinational picker taking Req and pointer, returning winner index and found flag. Both policies live there, selected by the macro.
- The top module holds the FSM, operand capture registers and result registers.

## Test plan
- Single request: Req=0001, A0=4'h7, B0=4'h8, Cin0=1.
  - Gnt=0001 one cycle later
  - Valid next cycle with Sum=4'h0, Overflow=1, ValidId=0
- All requesters, held continuously with distinct operands (A_i=i, B_i=1, Cin=0):
  - grants 0,1,2,3,0 every 2 cycles
  - Sum=i+1 with matching ValidId
  - with ADDER_ARB_FIXED_PRIO_EN, grants stay 0
- Operand change after grant: Req1 with A1=3, B1=2. Change A1 to 9 in the Gnt cycle. Result must be Sum=5, Overflow=0.
- Pointer wrap: requests 3 then 0 and 3 together.
  - grant 3, then 0
  - ValidId sequence 3,0
- Reset mid-EXEC: assert Rst during the Busy cycle.
  - all outputs are 0 the same cycle
  - no Valid follows
  - next request after release is granted from pointer 0
- Max operands: A=4'hF, B=4'hF, Cin=1 gives Sum=4'hF, Overflow=1.
